// File: rtl/cache_op_ctrl.sv
// CACHE-instruction sequencer between writeback and the I/D caches: one maintenance request per op.
// Optional watchdog enabled by defining CACHE_OP_WATCHDOG_EN.
module cache_op_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [1:0]        cache_target,
   input  logic [4:0]        cache_op,
   input  logic [ADDR_W-1:0] cache_paddr,
   input  logic [31:0]       cp0_taglo,
   output logic              cache_op_done,
   output logic              busy,
   output logic              icache_op_req,
   input  logic              icache_op_ack,
   input  logic              icache_op_resp,
   output logic              dcache_op_req,
   input  logic              dcache_op_ack,
   input  logic              dcache_op_resp,
   output logic [2:0]        op_code,
   output logic [ADDR_W-1:0] op_addr,
   output logic [31:0]       op_taglo,
   output logic              op_err
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_HOLD} state_e;

   state_e            state_q;
   logic              abort_q, sel_d_q, done_q, busy_q, ireq_q, dreq_q;
   logic [2:0]        op_code_q;
   logic [ADDR_W-1:0] op_addr_q;
   logic [31:0]       op_taglo_q;
   logic              op_ok, sel_ack, sel_resp, fin_ok, wd_hit;

   // Cache-select bits are implied by cache_target and not needed here.
   logic unused_sel;
   assign unused_sel = ^cache_op[1:0];

   always_comb begin
      op_ok = 1'b0;
      case (cache_target)
         2'b01:   op_ok = (cache_op[4:2] == 3'b000) || (cache_op[4:2] == 3'b010) ||
                          (cache_op[4:2] == 3'b100);
         2'b10:   op_ok = (cache_op[4:2] == 3'b000) || (cache_op[4:2] == 3'b010) ||
                          (cache_op[4:2] == 3'b100) || (cache_op[4:2] == 3'b101);
         default: op_ok = 1'b0;
      endcase
   end

   assign sel_ack  = sel_d_q ? dcache_op_ack  : icache_op_ack;
   assign sel_resp = sel_d_q ? dcache_op_resp : icache_op_resp;
   // Done is reported only for ops that saw no flush, including the cycle of entering DONE.
   assign fin_ok   = !(abort_q || flush);

`ifdef CACHE_OP_WATCHDOG_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
   logic [CNT_W-1:0] wd_q;
   logic             op_err_q;

   always_ff @(posedge clk) begin
      if (reset || !(state_q == S_REQ || state_q == S_WAIT)) wd_q <= '0;
      else                                                   wd_q <= wd_q + 1'b1;
   end
   assign wd_hit = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign op_err = op_err_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign wd_hit = 1'b0;
   assign op_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         abort_q    <= 1'b0;
         sel_d_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ireq_q     <= 1'b0;
         dreq_q     <= 1'b0;
         op_code_q  <= '0;
         op_addr_q  <= '0;
         op_taglo_q <= '0;
`ifdef CACHE_OP_WATCHDOG_EN
         op_err_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (state_q != S_IDLE && flush) abort_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (cache_target != 2'b00 && !flush) begin
                  op_code_q  <= cache_op[4:2];
                  op_addr_q  <= cache_paddr;
                  op_taglo_q <= cp0_taglo;
                  sel_d_q    <= cache_target[1];
                  busy_q     <= 1'b1;
                  if (op_ok) begin
                     state_q <= S_REQ;
                     ireq_q  <= (cache_target == 2'b01);
                     dreq_q  <= (cache_target == 2'b10);
                  end else begin
                     // Unsupported op retires as a NOP without touching either cache.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (sel_ack) begin
                  ireq_q <= 1'b0;
                  dreq_q <= 1'b0;
                  if (sel_resp) begin
                     state_q <= S_DONE;
                     done_q  <= fin_ok;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end else if (wd_hit) begin
                  ireq_q  <= 1'b0;
                  dreq_q  <= 1'b0;
                  state_q <= S_DONE;
                  done_q  <= fin_ok;
`ifdef CACHE_OP_WATCHDOG_EN
                  op_err_q <= 1'b1;
`endif
               end
            end
            S_WAIT: begin
               if (sel_resp) begin
                  state_q <= S_DONE;
                  done_q  <= fin_ok;
               end else if (wd_hit) begin
                  state_q <= S_DONE;
                  done_q  <= fin_ok;
`ifdef CACHE_OP_WATCHDOG_EN
                  op_err_q <= 1'b1;
`endif
               end
            end
            S_DONE: state_q <= S_HOLD;
            S_HOLD: begin
               // Wait for writeback to drop the target so the stale op is not re-run.
               if (cache_target == 2'b00) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cache_op_done = done_q && !flush;
   assign busy          = busy_q;
   assign icache_op_req = ireq_q;
   assign dcache_op_req = dreq_q;
   assign op_code       = op_code_q;
   assign op_addr       = op_addr_q;
   assign op_taglo      = op_taglo_q;

endmodule

// File: tb/tb_cache_op_ctrl.sv
// Randomized bench for cache_op_ctrl: responder with chosen ack/resp delays, transaction-level timing model.
module tb_cache_op_ctrl;
   localparam int ADDR_W = 32;
   localparam int TMO    = 8;

   logic              clk = 1'b0;
   logic              reset, flush;
   logic [1:0]        cache_target;
   logic [4:0]        cache_op;
   logic [ADDR_W-1:0] cache_paddr;
   logic [31:0]       cp0_taglo;
   logic              cache_op_done, busy, op_err;
   logic              icache_op_req, icache_op_ack, icache_op_resp;
   logic              dcache_op_req, dcache_op_ack, dcache_op_resp;
   logic [2:0]        op_code;
   logic [ADDR_W-1:0] op_addr;
   logic [31:0]       op_taglo;

   int n_chk = 0;
   int n_fail = 0;

   cache_op_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .cache_target(cache_target), .cache_op(cache_op), .cache_paddr(cache_paddr),
      .cp0_taglo(cp0_taglo), .cache_op_done(cache_op_done), .busy(busy),
      .icache_op_req(icache_op_req), .icache_op_ack(icache_op_ack), .icache_op_resp(icache_op_resp),
      .dcache_op_req(dcache_op_req), .dcache_op_ack(dcache_op_ack), .dcache_op_resp(dcache_op_resp),
      .op_code(op_code), .op_addr(op_addr), .op_taglo(op_taglo), .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit supported(input logic [1:0] tgt, input logic [2:0] op);
      if (tgt == 2'b01) return op == 3'd0 || op == 3'd2 || op == 3'd4;
      if (tgt == 2'b10) return op == 3'd0 || op == 3'd2 || op == 3'd4 || op == 3'd5;
      return 1'b0;
   endfunction

   task automatic idle_inputs();
      flush = 1'b0; cache_target = 2'b00; cache_op = '0; cache_paddr = '0; cp0_taglo = '0;
      icache_op_ack = 1'b0; icache_op_resp = 1'b0; dcache_op_ack = 1'b0; dcache_op_resp = 1'b0;
   endtask

   task automatic check_reset_state(input string nm);
      chk({nm, ".done"}, 64'(cache_op_done), 64'd0);
      chk({nm, ".busy"}, 64'(busy), 64'd0);
      chk({nm, ".ireq"}, 64'(icache_op_req), 64'd0);
      chk({nm, ".dreq"}, 64'(dcache_op_req), 64'd0);
      chk({nm, ".err"}, 64'(op_err), 64'd0);
      chk({nm, ".code"}, 64'(op_code), 64'd0);
      chk({nm, ".addr"}, 64'(op_addr), 64'd0);
      chk({nm, ".taglo"}, 64'(op_taglo), 64'd0);
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state(nm);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One op from cycle 0 (target first presented) until busy has fallen.
   // Ack comes A cycles after req rises, resp R cycles after ack; flush pulses at cycle F (-1 = none);
   // writeback keeps the target up H cycles past the done cycle.
   task automatic run_op(input string nm, input logic [1:0] tgt, input logic [4:0] op,
                         input logic [31:0] pa, input logic [31:0] tl,
                         input int A, input int R, input int F, input int H);
      bit sup     = supported(tgt, op[4:2]);
      int done_c  = sup ? 2 + A + R : 1;
      bit aborted = (F >= 1 && F <= done_c);
      int last_c  = done_c + H + 2;
      int reqcnt  = 0;
      int ack_c   = -1;
      bit sreq, sack, sresp;
      for (int c = 0; c <= last_c; c++) begin
         cache_target = (c <= done_c + H) ? tgt : 2'b00;
         cache_op     = (c == 0) ? op : 5'($urandom);
         cache_paddr  = (c == 0) ? pa : $urandom;
         cp0_taglo    = (c == 0) ? tl : $urandom;
         flush        = (c == F);
         sreq  = (tgt == 2'b01) ? icache_op_req : dcache_op_req;
         sack  = sreq && (reqcnt == A);
         if (sreq) reqcnt++;
         if (sack) ack_c = c;
         sresp = (ack_c >= 0) && (c == ack_c + R);
         if (tgt == 2'b01) begin
            icache_op_ack = sack; icache_op_resp = sresp;
            dcache_op_ack = 1'($urandom); dcache_op_resp = 1'($urandom);
         end else begin
            dcache_op_ack = sack; dcache_op_resp = sresp;
            icache_op_ack = 1'($urandom); icache_op_resp = 1'($urandom);
         end
         @(negedge clk);
         chk($sformatf("%s.busy@%0d", nm, c), 64'(busy), 64'(c >= 1 && c <= done_c + H + 1));
         chk($sformatf("%s.ireq@%0d", nm, c), 64'(icache_op_req),
             64'(sup && tgt == 2'b01 && c >= 1 && c <= 1 + A));
         chk($sformatf("%s.dreq@%0d", nm, c), 64'(dcache_op_req),
             64'(sup && tgt == 2'b10 && c >= 1 && c <= 1 + A));
         chk($sformatf("%s.done@%0d", nm, c), 64'(cache_op_done), 64'(!aborted && c == done_c));
         chk($sformatf("%s.err@%0d", nm, c), 64'(op_err), 64'd0);
         if (c >= 1) begin
            chk($sformatf("%s.code@%0d", nm, c), 64'(op_code), 64'(op[4:2]));
            chk($sformatf("%s.addr@%0d", nm, c), 64'(op_addr), 64'(pa));
            chk($sformatf("%s.taglo@%0d", nm, c), 64'(op_taglo), 64'(tl));
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         idle_inputs();
         flush = 1'($urandom);
         @(negedge clk);
         chk("gap.busy", 64'(busy), 64'd0);
         chk("gap.done", 64'(cache_op_done), 64'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [1:0] t;
      logic [4:0] o;
      int a, r, f, d;
      idle_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      do_reset("rst0");

      run_op("dhwbi", 2'b10, 5'b10101, 32'h1FC0_0040, 32'h1234_5678, 0, 1, -1, 0);
      gap(1);
      run_op("istag", 2'b01, 5'b01000, 32'h0000_1000, 32'hDEAD_0001, 4, 3, -1, 0);
      gap(1);
      run_op("inop", 2'b01, 5'b00100, 32'h0000_2000, 32'h0, 0, 0, -1, 1);
      gap(1);
      run_op("flwait", 2'b01, 5'b10000, 32'h0000_3000, 32'h5, 1, 3, 4, 0);
      run_op("after", 2'b10, 5'b00001, 32'h0000_4000, 32'h6, 1, 1, -1, 0);
      run_op("hold2", 2'b10, 5'b00001, 32'h0000_5000, 32'h7, 0, 1, -1, 2);
      run_op("fldone", 2'b10, 5'b01001, 32'h0000_6000, 32'h8, 0, 0, 2, 0);
      gap(2);

      for (int k = 0; k < 40; k++) begin
         t = 2'($urandom_range(1, 2));
         o = {3'($urandom), (t == 2'b01) ? 2'b00 : 2'b01};
         a = $urandom_range(0, 4);
         r = $urandom_range(0, 3);
         d = supported(t, o[4:2]) ? 2 + a + r : 1;
         f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d + 2) : -1;
         run_op($sformatf("rnd%0d", k), t, o, $urandom, $urandom, a, r, f, $urandom_range(0, 2));
         gap($urandom_range(0, 2));
      end

`ifdef CACHE_OP_WATCHDOG_EN
      for (int c = 0; c <= 12; c++) begin
         cache_target = (c <= 10) ? 2'b01 : 2'b00;
         cache_op = 5'b00000; cache_paddr = 32'hA0; cp0_taglo = 32'h0;
         @(negedge clk);
         chk($sformatf("wd.ireq@%0d", c), 64'(icache_op_req), 64'(c >= 1 && c <= TMO));
         chk($sformatf("wd.done@%0d", c), 64'(cache_op_done), 64'(c == TMO + 1));
         chk($sformatf("wd.err@%0d", c), 64'(op_err), 64'(c >= TMO + 1));
         @(posedge clk); #1;
      end
      idle_inputs();
`endif

      do_reset("rst1");
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog sim time limit reached");
      $fatal(1);
   end
endmodule
